// File: rtl/imem_dmem_port_arbiter_if.sv
// Bus bundle between the pipeline (fetch and mem stages), the arbiter and the
// unified single-port memory. The arbiter takes the slave view; the pipeline
// and memory side (or a testbench standing in for them) takes the master view.
interface imem_dmem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, i_flush,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr, i_flush,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data port has fixed priority; a pending fetch that has lost MAX_WAIT
// consecutive conflicts is forced through. Read data returns one cycle after
// grant, tagged by a registered owner state.
// Optional macro ARB_STATS_EN adds saturating conflict / forced-grant counters.
//
// state    | meaning
// OWN_NONE | no read response due next cycle (idle, store, flushed fetch)
// OWN_RD_I | fetch read granted last cycle; next cycle drives i_rvalid
// OWN_RD_D | data load granted last cycle; next cycle drives d_rvalid
module imem_dmem_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int WCW      = 3
) (
  input  logic clk,
  input  logic rst_n,
  imem_dmem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] stat_conflict,
  output logic [15:0] stat_forced
`endif
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RD_I = 2'd1,
    OWN_RD_D = 2'd2
  } owner_e;

  localparam logic [WCW-1:0] MAX_WAIT_W = WCW'(MAX_WAIT);

  owner_e         owner_q, owner_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           starve;
  logic           i_gnt_w, d_gnt_w;

  // State register: owner tag and fetch wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      wait_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Grant decision, memory mux, next owner / wait count and response outputs.
  always_comb begin
    starve         = (wait_cnt_q >= MAX_WAIT_W);
    i_gnt_w        = bus.i_req & (~bus.d_req | starve);
    d_gnt_w        = bus.d_req & ~i_gnt_w;

    bus.i_gnt      = i_gnt_w;
    bus.d_gnt      = d_gnt_w;
    bus.mem_en     = i_gnt_w | d_gnt_w;
    bus.mem_we     = d_gnt_w & bus.d_we;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (d_gnt_w) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (i_gnt_w) begin
      bus.mem_addr  = bus.i_addr;
    end

    // A fetch that is waiting but not served ages toward the forced grant.
    wait_cnt_d = wait_cnt_q;
    if (!bus.i_req || i_gnt_w) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_WAIT_W) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end

    owner_d = OWN_NONE;
    if (i_gnt_w && !bus.i_flush) begin
      owner_d = OWN_RD_I;
    end else if (d_gnt_w && !bus.d_we) begin
      owner_d = OWN_RD_D;
    end

    bus.i_rvalid = (owner_q == OWN_RD_I);
    bus.d_rvalid = (owner_q == OWN_RD_D);
    bus.i_rdata  = bus.mem_rdata;
    bus.d_rdata  = bus.mem_rdata;
  end

`ifdef ARB_STATS_EN
  logic [15:0] stat_conflict_q, stat_forced_q;

  // Saturating counters: conflict cycles and starvation-forced fetch grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflict_q <= '0;
      stat_forced_q   <= '0;
    end else begin
      if (bus.i_req && bus.d_req && stat_conflict_q != 16'hFFFF) begin
        stat_conflict_q <= stat_conflict_q + 16'd1;
      end
      if (i_gnt_w && bus.d_req && stat_forced_q != 16'hFFFF) begin
        stat_forced_q <= stat_forced_q + 16'd1;
      end
    end
  end

  assign stat_conflict = stat_conflict_q;
  assign stat_forced   = stat_forced_q;
`endif

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed-vector bench for imem_dmem_port_arbiter with a queue scoreboard:
// the driver checks grants each cycle and pushes the expected read response;
// a negedge monitor pops and compares whenever an rvalid is seen.
module tb_imem_dmem_port_arbiter;

  logic clk;
  logic rst_n;

  imem_dmem_port_arbiter_if #(.AW(10), .DW(32)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] stat_conflict, stat_forced;
`endif

  imem_dmem_port_arbiter #(.AW(10), .DW(32), .MAX_WAIT(4), .WCW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_conflict (stat_conflict),
    .stat_forced   (stat_forced)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: single port, registered read.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  typedef struct packed {
    logic        is_i;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Grant/strobe encodings {i_gnt, d_gnt, mem_en, mem_we}
  localparam logic [3:0] G_IDLE  = 4'b0000;
  localparam logic [3:0] G_FETCH = 4'b1010;
  localparam logic [3:0] G_LOAD  = 4'b0110;
  localparam logic [3:0] G_STORE = 4'b0111;
  localparam int R_NONE = 0;
  localparam int R_I    = 1;
  localparam int R_D    = 2;

  // Monitor: every presented response must match the head of the queue.
  exp_t        mon_e;
  logic [31:0] mon_data;
  always @(negedge clk) begin
    if (bus.i_rvalid || bus.d_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid: got i_rvalid=%b d_rvalid=%b, required none", bus.i_rvalid, bus.d_rvalid);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_data = bus.i_rvalid ? bus.i_rdata : bus.d_rdata;
        if ((bus.i_rvalid && bus.d_rvalid) || (bus.i_rvalid != mon_e.is_i) || (mon_data !== mon_e.data)) begin
          failures++;
          $display("FAIL response: got i_rvalid=%b d_rvalid=%b data=%h, required is_i=%b data=%h",
                   bus.i_rvalid, bus.d_rvalid, mon_data, mon_e.is_i, mon_e.data);
        end
      end
    end
  end

  // One cycle of stimulus: drive at posedge+1, check grants at negedge.
  task automatic step(input logic ir, input logic [9:0] ia, input logic fl,
                      input logic dr, input logic dwe, input logic [9:0] da,
                      input logic [31:0] dwd, input logic [3:0] exp_g,
                      input int rkind, input logic [31:0] rdata, input string name);
    logic [3:0] got;
    bus.i_req = ir; bus.i_addr = ia; bus.i_flush = fl;
    bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
    @(negedge clk);
    got = {bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we};
    checks++;
    if (got !== exp_g) begin
      failures++;
      $display("FAIL %s grants: got {i_gnt,d_gnt,mem_en,mem_we}=%b required %b", name, got, exp_g);
    end
    if (rkind != R_NONE) exp_q.push_back('{is_i: (rkind == R_I), data: rdata});
    @(posedge clk); #1;
  endtask

  task automatic idle(input string name);
    step(0, 10'd0, 0, 0, 0, 10'd0, 32'h0, G_IDLE, R_NONE, 32'h0, name);
  endtask

  task automatic check_rvalid_low(input string name);
    checks++;
    if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL %s: got i_rvalid=%b d_rvalid=%b required 0 0", name, bus.i_rvalid, bus.d_rvalid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'h2001_0007;
    bus.mem_rdata = '0;
    rst_n = 1'b0;
    bus.i_req = 0; bus.i_addr = '0; bus.i_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_state: got rv_i=%b rv_d=%b gi=%b gd=%b en=%b we=%b required all 0",
               bus.i_rvalid, bus.d_rvalid, bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch only
    step(1, 10'd5, 0, 0, 0, 10'd0, 32'h0, G_FETCH, R_I, 32'h2001_0007, "fetch_only");
    idle("fetch_only_idle");

    // Store then load
    step(0, 10'd0, 0, 1, 1, 10'd100, 32'hDEAD_BEEF, G_STORE, R_NONE, 32'h0, "store");
    step(0, 10'd0, 0, 1, 0, 10'd100, 32'h0, G_LOAD, R_D, 32'hDEAD_BEEF, "load_after_store");
    idle("store_load_idle");

    // Starvation: 4 data wins, forced fetch, then data again
    for (int k = 0; k < 4; k++)
      step(1, 10'd6, 0, 1, 0, 10'd7, 32'h0, G_LOAD, R_D, 32'h1000_0007, "starve_data");
    step(1, 10'd6, 0, 1, 0, 10'd7, 32'h0, G_FETCH, R_I, 32'h1000_0006, "starve_forced");
`ifdef ARB_STATS_EN
    checks++;
    if (stat_forced !== 16'd1) begin
      failures++;
      $display("FAIL stat_forced: got %0d required 1", stat_forced);
    end
`endif
    step(1, 10'd6, 0, 1, 0, 10'd7, 32'h0, G_LOAD, R_D, 32'h1000_0007, "starve_after");
    idle("starve_idle");

    // Dropping the fetch request clears the wait count
    step(1, 10'd6, 0, 1, 0, 10'd8, 32'h0, G_LOAD, R_D, 32'h1000_0008, "drop_pre");
    step(1, 10'd6, 0, 1, 0, 10'd8, 32'h0, G_LOAD, R_D, 32'h1000_0008, "drop_pre");
    step(0, 10'd6, 0, 1, 0, 10'd8, 32'h0, G_LOAD, R_D, 32'h1000_0008, "drop_gap");
    for (int k = 0; k < 4; k++)
      step(1, 10'd6, 0, 1, 0, 10'd8, 32'h0, G_LOAD, R_D, 32'h1000_0008, "drop_post");
    step(1, 10'd6, 0, 1, 0, 10'd8, 32'h0, G_FETCH, R_I, 32'h1000_0006, "drop_forced");
    idle("drop_idle");

    // Flush: flushed fetch reads memory but gives no response
    step(1, 10'd5, 1, 0, 0, 10'd0, 32'h0, G_FETCH, R_NONE, 32'h0, "flush_granted");
    idle("flush_idle");
    // Flush high only in a cycle where the fetch loses: ignored
    step(1, 10'd5, 1, 1, 0, 10'd9, 32'h0, G_LOAD, R_D, 32'h1000_0009, "flush_not_granted");
    step(1, 10'd5, 0, 0, 0, 10'd0, 32'h0, G_FETCH, R_I, 32'h2001_0007, "fetch_after_flush");
    idle("flush_idle2");

    // Back-to-back alternating fetch / load
    step(1, 10'd8,  0, 0, 0, 10'd0,  32'h0, G_FETCH, R_I, 32'h1000_0008, "b2b_f8");
    step(0, 10'd0,  0, 1, 0, 10'd9,  32'h0, G_LOAD,  R_D, 32'h1000_0009, "b2b_l9");
    step(1, 10'd10, 0, 0, 0, 10'd0,  32'h0, G_FETCH, R_I, 32'h1000_000A, "b2b_f10");
    step(0, 10'd0,  0, 1, 0, 10'd11, 32'h0, G_LOAD,  R_D, 32'h1000_000B, "b2b_l11");
    idle("b2b_idle");

    // Fetch after store to same address sees the stored value
    step(0, 10'd0,  0, 1, 1, 10'd12, 32'h0BAD_F00D, G_STORE, R_NONE, 32'h0, "store12");
    step(1, 10'd12, 0, 0, 0, 10'd0,  32'h0, G_FETCH, R_I, 32'h0BAD_F00D, "fetch12");
    idle("store_fetch_idle");

    // Reset mid-read: build up wait count, reset in the cycle after a load grant
    step(1, 10'd6, 0, 1, 0, 10'd7, 32'h0, G_LOAD, R_D, 32'h1000_0007, "rst_pre");
    step(1, 10'd6, 0, 1, 0, 10'd7, 32'h0, G_LOAD, R_NONE, 32'h0, "rst_load");
    bus.i_req = 0; bus.d_req = 0;
    rst_n = 1'b0;
    #1;
    check_rvalid_low("rst_mid_read");
    repeat (2) @(posedge clk);
    #1;
    check_rvalid_low("rst_held");
    rst_n = 1'b1;
    // Wait count must restart at 0: four data wins before the forced fetch
    for (int k = 0; k < 4; k++)
      step(1, 10'd10, 0, 1, 0, 10'd9, 32'h0, G_LOAD, R_D, 32'h1000_0009, "rst_post_data");
    step(1, 10'd10, 0, 1, 0, 10'd9, 32'h0, G_FETCH, R_I, 32'h1000_000A, "rst_post_forced");
    idle("end_idle");
    idle("end_idle");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_responses: got %0d outstanding required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
